delay_line_pipe: RTL and testbench

// - Parametrised register delay line; next generation of the two-stage 2-bit register chain.
// - Carries WIDTH-bit data plus a valid bit through DEPTH register stages.
// - Output tap is selectable at runtime, giving a delay of 1..DEPTH cycles.
// - Supports stall (en), flush and an occupancy count; sits between a source and a sink as a timing-alignment element.

---
 rtl/delay_line_pipe_pkg.sv | 9 +
 rtl/delay_stage.sv | 46 ++++
 rtl/delay_line_pipe.sv | 83 ++++++++
 tb/tb_delay_line_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/delay_line_pipe_pkg.sv
// Shared helpers for the delay_line_pipe register delay line.
package delay_line_pipe_pkg;

    // Limits a requested tap index to the deepest stage that exists.
    function automatic int clamp_tap(int sel, int depth);
        return (sel > depth - 1) ? depth - 1 : sel;
    endfunction

endpackage

// File: rtl/delay_stage.sv
// One {valid,data} register of the delay line, with hold (en) and valid clear (flush).
module delay_stage #(
    parameter int WIDTH = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    always_comb begin
        // NOTE: hold values are assigned first so no path through this block infers a latch.
        valid_d = valid_q;
        data_d  = data_q;
        if (en) begin
            valid_d = d_valid;
            data_d  = d_data;
        end
        // Flush wins over en; the data bits may go stale, valid qualifies them.
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: non-blocking updates make every stage sample its neighbour's pre-edge value.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign q_valid = valid_q;
    assign q_data  = data_q;

endmodule

// File: rtl/delay_line_pipe.sv
// Parametrised valid/data delay line with a runtime-selectable output tap,
// stall, flush and an occupancy count.
module delay_line_pipe
    import delay_line_pipe_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2,
    parameter int TAP_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             en,
    input  logic             flush,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [CNT_W-1:0] occ
);

    logic [DEPTH-1:0] st_valid;
    logic [WIDTH-1:0] st_data [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            delay_stage #(.WIDTH(WIDTH)) u_stage (
                .sys_clk   (sys_clk),
                .sys_rst_n (sys_rst_n),
                .en        (en),
                .flush     (flush),
                .d_valid   (in_valid),
                .d_data    (in_data),
                .q_valid   (st_valid[k]),
                .q_data    (st_data[k])
            );
        end else begin : g_body
            delay_stage #(.WIDTH(WIDTH)) u_stage (
                .sys_clk   (sys_clk),
                .sys_rst_n (sys_rst_n),
                .en        (en),
                .flush     (flush),
                .d_valid   (st_valid[k-1]),
                .d_data    (st_data[k-1]),
                .q_valid   (st_valid[k]),
                .q_data    (st_data[k])
            );
        end
    end

    logic [TAP_W-1:0] tap_d, tap_q;
    logic [CNT_W-1:0] occ_d, occ_q;

    always_comb begin
        // Clamping at registration keeps the output mux index inside the line.
        tap_d = TAP_W'(clamp_tap(32'(tap_sel), DEPTH));
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (en) begin
            occ_d = occ_q + CNT_W'(in_valid) - CNT_W'(st_valid[DEPTH-1]);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tap_q <= '0;
            occ_q <= '0;
        end else begin
            tap_q <= tap_d;
            occ_q <= occ_d;
        end
    end

    assign out_data  = st_data[tap_q];
    assign out_valid = st_valid[tap_q];
    assign occ       = occ_q;

    occ_matches_valids: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        occ_q == CNT_W'($countones(st_valid)));

endmodule

// File: tb/tb_delay_line_pipe.sv
// Drives four delay_line_pipe instances (DEPTH 2/8/4/5) from shared stimulus and
// compares them against a history-log model of accepted words.
module tb_delay_line_pipe;

    localparam int N          = 4;
    localparam int DEP   [N]  = '{2, 8, 4, 5};
    localparam int TMASK [N]  = '{1, 7, 3, 7};
    localparam int LOG_SZ     = 4096;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       en = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] tsel [N];

    logic [1:0] od2;
    logic [7:0] od8, od4, od5;
    logic [1:0] oc2;
    logic [3:0] oc8;
    logic [2:0] oc4, oc5;
    logic       ov [N];
    logic [7:0] od [N];
    logic [3:0] oc [N];

    always #5 sys_clk = ~sys_clk;

    delay_line_pipe #(.WIDTH(2), .DEPTH(2)) u_d2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data[1:0]), .in_valid(in_valid),
        .en(en), .flush(flush), .tap_sel(tsel[0][0:0]), .out_data(od2), .out_valid(ov[0]), .occ(oc2));
    delay_line_pipe #(.WIDTH(8), .DEPTH(8)) u_d8 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data), .in_valid(in_valid),
        .en(en), .flush(flush), .tap_sel(tsel[1]), .out_data(od8), .out_valid(ov[1]), .occ(oc8));
    delay_line_pipe #(.WIDTH(8), .DEPTH(4)) u_d4 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data), .in_valid(in_valid),
        .en(en), .flush(flush), .tap_sel(tsel[2][1:0]), .out_data(od4), .out_valid(ov[2]), .occ(oc4));
    delay_line_pipe #(.WIDTH(8), .DEPTH(5)) u_d5 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data), .in_valid(in_valid),
        .en(en), .flush(flush), .tap_sel(tsel[3]), .out_data(od5), .out_valid(ov[3]), .occ(oc5));

    assign od[0] = {6'b0, od2};
    assign od[1] = od8;
    assign od[2] = od4;
    assign od[3] = od5;
    assign oc[0] = {2'b0, oc2};
    assign oc[1] = oc8;
    assign oc[2] = {1'b0, oc4};
    assign oc[3] = {1'b0, oc5};

    // Reference model: a log of every word accepted on an enabled edge. Words
    // logged before the most recent flush mark count as invalid.
    logic [7:0] ld [LOG_SZ];
    logic       lv [LOG_SZ];
    int         wp, fmark;
    int         tmod [N];
    int         n_pass, n_fail, n_total;

    function automatic int min_int(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        wp    = 0;
        fmark = 0;
        for (int i = 0; i < N; i++) tmod[i] = 0;
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) tmod[i] = min_int(int'(tsel[i]) & TMASK[i], DEP[i] - 1);
        if (en) begin
            ld[wp] = in_data;
            lv[wp] = in_valid;
            wp++;
        end
        if (flush) fmark = wp;
    endtask

    function automatic logic [8:0] exp_tap(int i, int t);
        int idx;
        logic [7:0] mask;
        idx  = wp - 1 - t;
        mask = (i == 0) ? 8'h03 : 8'hFF;
        if (idx < 0) return 9'h0;
        return {lv[idx] && (idx >= fmark), ld[idx] & mask};
    endfunction

    function automatic int exp_occ(int i);
        int n;
        int idx;
        n = 0;
        for (int j = 0; j < DEP[i]; j++) begin
            idx = wp - 1 - j;
            if (idx >= 0 && idx >= fmark && lv[idx]) n++;
        end
        return n;
    endfunction

    task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s depth%0d: observed %0h expected %0h", tag, DEP[i], obs, exp);
        end
    endtask

    task automatic check_all();
        logic [8:0] e;
        for (int i = 0; i < N; i++) begin
            e = exp_tap(i, tmod[i]);
            check("out_valid", i, 32'(ov[i]), 32'(e[8]));
            if (e[8]) check("out_data", i, 32'(od[i]), 32'(e[7:0]));
            check("occ", i, 32'(oc[i]), 32'(exp_occ(i)));
        end
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic cycle();
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        check_all();
    endtask

    task automatic rand_taps();
        for (int i = 0; i < N; i++) tsel[i] = 3'($urandom_range(0, 7));
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0;
        for (int i = 0; i < N; i++) tsel[i] = '0;
        model_reset();

        // Reset values while sys_rst_n is held low.
        #12;
        check_all();
        for (int i = 0; i < N; i++) check("rst_data", i, 32'(od[i]), 32'h0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Basic random stream, 2-cycle tap on the DEPTH=2 line.
        en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            rand_taps();
            tsel[0]  = 3'd1;
            in_data  = 8'($urandom);
            in_valid = 1'($urandom);
            cycle();
        end

        // Tap sweep on the DEPTH=8 line with an index-valued stream.
        in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tsel[1] = 3'(c / 5);
            in_data = 8'(c);
            cycle();
        end

        // Stall: stream 1..4, hold en low for 3 cycles with junk inputs, resume.
        tsel[2] = 3'd3;
        for (int c = 1; c <= 4; c++) begin
            in_data = 8'(c); in_valid = 1'b1; en = 1'b1;
            cycle();
        end
        for (int c = 0; c < 3; c++) begin
            en = 1'b0; in_data = 8'($urandom); in_valid = 1'($urandom);
            cycle();
        end
        for (int c = 5; c <= 10; c++) begin
            in_data = 8'(c); in_valid = 1'b1; en = 1'b1;
            cycle();
        end
        check("stall_full_occ", 2, 32'(oc[2]), 32'd4);

        // Flush with en=1 and in_valid=1 on a full line.
        flush = 1'b1; in_data = 8'hA5;
        cycle();
        check("flush_occ", 2, 32'(oc[2]), 32'd0);
        flush = 1'b0; en = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tsel[2] = 3'(t);
            cycle();
        end
        en = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = 8'(8'h30 + c);
            cycle();
        end
        check("pre_arst_occ", 2, 32'(oc[2]), 32'd3);

        // Asynchronous reset between edges.
        en = 1'b0;
        @(posedge sys_clk);
        model_step();
        #2 sys_rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            check("arst_valid", i, 32'(ov[i]), 32'h0);
            check("arst_occ", i, 32'(oc[i]), 32'h0);
            check("arst_data", i, 32'(od[i]), 32'h0);
        end
        model_reset();
        @(negedge sys_clk);
        check_all();
        sys_rst_n = 1'b1;

        // Out-of-range tap on the DEPTH=5 line.
        en = 1'b1;
        tsel[3] = 3'd7;
        for (int c = 0; c < 30; c++) begin
            in_data = 8'($urandom); in_valid = 1'($urandom);
            cycle();
        end

        // Mixed random traffic: stalls, flushes, tap changes.
        for (int c = 0; c < 250; c++) begin
            rand_taps();
            in_data  = 8'($urandom);
            in_valid = 1'($urandom);
            en       = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
